// File: rtl/aes_out_ser.sv
// aes_out_ser: output serializer for the AES-256 final round state.
// Captures the 16-byte round-14 state and streams it one byte per
// valid/ready handshake. A single pending buffer lets the next block land
// while the current one drains, so consecutive blocks leave without a bubble.
module aes_out_ser #(
   parameter int N = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [3:0]        round,
   input  logic [N-1:0][7:0] i,
   output logic              in_rdy,
   output logic [7:0]        o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              o_last,
   output logic              busy,
   output logic [7:0]        blk_cnt,
   output logic              ovf
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N-1:0][7:0] r_act;
   logic [N-1:0][7:0] r_pend;
   logic              r_pend_v;
   logic [3:0]        r_idx;
   logic [7:0]        r_blk_cnt;
   logic              r_ovf;

   logic              w_strobe;
   logic              w_cap;
   logic              w_xfer;
   logic              w_last;

   // Only the final round's state write is a candidate for capture; the
   // pending flag is the sole backpressure source towards the core.
   assign w_strobe = wr_en && (round == 4'd14);
   assign w_cap    = w_strobe && !r_pend_v;
   assign w_xfer   = o_valid && o_ready;
   assign w_last   = w_xfer && (r_idx == 4'hF);

   // Ready comes straight off the pending flop, keeping o_ready out of the path.
   assign in_rdy  = !r_pend_v;
   assign o_valid = (r_state == S_STREAM);
   assign o_data  = r_act[r_idx];
   assign o_last  = o_valid && (r_idx == 4'hF);
   assign busy    = o_valid || r_pend_v;
   assign blk_cnt = r_blk_cnt;
   assign ovf     = r_ovf;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: leave STREAM only when the last byte goes and nothing follows.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_cap) w_state_nxt = S_STREAM;
         S_STREAM: if (w_last && !r_pend_v && !w_cap) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Buffers, byte index, block counter and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_act     <= '0;
         r_pend    <= '0;
         r_pend_v  <= 1'b0;
         r_idx     <= 4'd0;
         r_blk_cnt <= 8'd0;
         r_ovf     <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            if (w_cap) begin
               r_act <= i;
               r_idx <= 4'd0;
            end
         end else if (w_last) begin
            // Block boundary: pending block wins; otherwise a same-cycle
            // capture goes directly into the active buffer.
            r_idx <= 4'd0;
            if (r_pend_v) begin
               r_act    <= r_pend;
               r_pend_v <= 1'b0;
            end else if (w_cap) begin
               r_act <= i;
            end
         end else begin
            if (w_cap) begin
               r_pend   <= i;
               r_pend_v <= 1'b1;
            end
            if (w_xfer) r_idx <= r_idx + 4'd1;
         end
         if (w_last) r_blk_cnt <= r_blk_cnt + 8'd1;
         if (w_strobe && r_pend_v) r_ovf <= 1'b1;
      end
   end

endmodule

// File: doc/aes_out_ser.md
# aes_out_ser

Output serializer for the AES-256 datapath: the reader side of the 16-byte round-state register. When the core presents the final (round 14) state with its write enable, this block captures the 16 bytes and streams them out one byte per handshake on a valid/ready byte interface. A one-block pending buffer lets the core hand over the next ciphertext block while the current one is still streaming, so back-to-back blocks leave with no bubble.

## Interface

Parameters:
- N, 16, bytes per block (state width); only 16 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  state-write strobe from the core; this block captures on it only when round == 14.
- round  in  4  current round number from the core controller.
- i  in  [N-1:0][7:0]  final state bytes; i[0] is the first byte out.
- in_rdy  out  1  registered; 1 = a capture will be accepted this cycle.
- o_data  out  8  output byte.
- o_valid  out  1  o_data valid.
- o_ready  in  1  downstream accepts o_data.
- o_last  out  1  high with o_valid on byte 15 of a block.
- busy  out  1  o_valid | pend_v.
- blk_cnt  out  8  count of fully transmitted blocks; wraps 255 -> 0.
- ovf  out  1  sticky: a capture was presented while in_rdy = 0; cleared only by reset.

## Operation

- Storage:
  - active buffer act[15:0][7:0] with byte index idx (4 bits);
  - pending buffer pend[15:0][7:0] with flag pend_v.
- The state machine is tracked by o_valid:
  - IDLE (o_valid = 0);
  - STREAM (o_valid = 1).
- Capture condition: cap = wr_en && round == 14 && in_rdy.
  - in_rdy = !pend_v, taken from the registered flag.
- xfer = o_valid && o_ready; last = xfer && idx == 15.
- IDLE + cap: i -> act, idx <= 0, go to STREAM.
- STREAM, no last:
  - cap: i -> pend, pend_v <= 1.
  - xfer: idx <= idx + 1.
- STREAM + last:
  - blk_cnt <= blk_cnt + 1.
  - If pend_v: pend -> act, pend_v <= 0, idx <= 0, stay in STREAM.
  - Else if cap: i -> act, idx <= 0, stay in STREAM.
  - Else: go to IDLE.
- Data and flags:
  - o_data = act[idx]; o_last = o_valid && idx == 15.
  - While o_valid && !o_ready: o_data, o_last and idx are held stable.
- Ignored inputs:
  - wr_en with round != 14 is ignored, with no flag.
  - wr_en && round == 14 && !in_rdy: the data is dropped, ovf <= 1, and act/pend are unchanged.
- Reset (asynchronous, any time, including mid-block): all outputs and state go to 0 (o_valid, o_last, busy, ovf, blk_cnt, o_data, idx, pend_v). in_rdy = 1 from the first cycle after reset deasserts. Any partial block is discarded.

## Timing

- Capture to first byte: o_valid = 1 with o_data = i[0] in the cycle after cap.
- Block throughput: 16 cycles with o_ready held at 1; one byte per cycle.
- Back-to-back blocks:
  - Byte 0 of the next block follows byte 15 of the current block in the next cycle when pend_v = 1, or when cap coincides with last.
- in_rdy:
  - Drops the cycle after a pend capture.
  - Rises the cycle after pend moves to act; no combinational path from o_ready to in_rdy.
- blk_cnt: updates the cycle after the last transfer.
- ovf: sets the cycle after the dropped strobe.

## Test plan

- Reset then single block: i = 00..0F, round = 14, wr_en for 1 cycle, o_ready = 1.
  - Bytes 00..0F appear on 16 consecutive cycles; o_last only on 0F; blk_cnt = 1; then o_valid = 0 and busy = 0.
- Backpressure: o_ready toggling 1,0,0,1, ...
  - o_data stays stable while stalled; the sequence is unchanged; no byte is duplicated or skipped.
- Back-to-back blocks: block A captured, then block B captured 3 cycles later, o_ready = 1.
  - in_rdy = 0 from cycle 4 until B moves to act.
  - 32 consecutive bytes; o_last at bytes 15 and 31; blk_cnt = 2.
- Overflow and round filter:
  - Third capture while pend_v = 1 -> ovf = 1, output stream unchanged.
  - wr_en with round = 13 -> no capture, ovf stays 0.
- Reset mid-block: assert reset at byte 7.
  - o_valid and busy fall immediately; no further bytes; blk_cnt = 0.
  - A new capture after release streams from byte 0.
- Counter wrap: 256 blocks streamed -> blk_cnt returns to 0.
